pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_pkg.sv | 23 ++
 rtl/pipelined_adder_if.sv | 32 +++
 rtl/pipelined_adder_stage.sv | 23 ++
 rtl/pipelined_adder.sv | 127 ++++++++++++
 tb/tb_pipelined_adder.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared constants and stage-bundle layout for the carry-skewed pipelined adder.
// The top module rebuilds the same bundle at its own WIDTH.

package pipelined_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // One stage register: partial sum grows by one chunk per stage while the
  // not-yet-added operand chunks ride along (b already inverted for subtract).
  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] psum;
    logic                 carry;
    logic [DEF_WIDTH-1:0] a_rem;
    logic [DEF_WIDTH-1:0] b_rem;
  } stage_bundle_t;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle of the pipelined adder.
// The adder takes the slave view and the producer/consumer take the master view.

interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, flush, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, flush, out_ready,
    output in_ready, out_valid, sum, c_out, overflow, zero
  );

endinterface

// File: rtl/pipelined_adder_stage.sv
// One CHUNK-wide combinational add slice with carry in/out.
// It also exposes the carry into its top bit so the last slice can flag signed overflow.

module adder_stage
  import pipelined_adder_pkg::*;
#(
  parameter int CHUNK = chunk_width(DEF_WIDTH, DEF_STAGES)
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             c_o,
  output logic             c_msb_o
);

  always_comb begin
    {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the XOR.
    c_msb_o      = sum_o[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple adder/subtractor: stage k adds chunk k with the registered carry of stage k-1.
// A single global stall comes from the output handshake, and flush drops all in-flight work.

module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_adder_if.slave   bus
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
  } stage_t;

  stage_t [STAGES-1:0]            stage_q;
  stage_t [STAGES-1:0]            stage_d;
  logic                           overflow_q;
  logic                           overflow_d;
  logic                           zero_q;
  logic                           zero_d;

  logic                           stall;
  logic                           accept;
  logic [WIDTH-1:0]               b_inv;
  logic [STAGES-1:0][CHUNK-1:0]   st_sum;
  logic [STAGES-1:0]              st_cout;
  logic [STAGES-1:0]              st_cmsb;

  assign stall        = stage_q[STAGES-1].valid && !bus.out_ready;
  assign bus.in_ready = !stall && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign b_inv        = bus.b ^ {WIDTH{bus.sub}};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] op_a;
    logic [CHUNK-1:0] op_b;
    logic             c_in;

    if (k == 0) begin : g_first
      assign op_a = bus.a[CHUNK-1:0];
      assign op_b = b_inv[CHUNK-1:0];
      assign c_in = bus.sub;
    end else begin : g_rest
      assign op_a = stage_q[k-1].a_rem[k*CHUNK +: CHUNK];
      assign op_b = stage_q[k-1].b_rem[k*CHUNK +: CHUNK];
      assign c_in = stage_q[k-1].carry;
    end

    adder_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .a_i     (op_a),
      .b_i     (op_b),
      .c_i     (c_in),
      .sum_o   (st_sum[k]),
      .c_o     (st_cout[k]),
      .c_msb_o (st_cmsb[k])
    );
  end

  always_comb begin
    stage_d    = stage_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    if (!stall) begin
      stage_d[0].valid            = accept;
      stage_d[0].psum             = '0;
      stage_d[0].psum[CHUNK-1:0]  = st_sum[0];
      stage_d[0].carry            = st_cout[0];
      stage_d[0].a_rem            = bus.a;
      stage_d[0].b_rem            = b_inv;

      for (int k = 1; k < STAGES; k++) begin
        stage_d[k].valid                     = stage_q[k-1].valid;
        stage_d[k].psum                      = stage_q[k-1].psum;
        stage_d[k].psum[k*CHUNK +: CHUNK]    = st_sum[k];
        stage_d[k].carry                     = st_cout[k];
        stage_d[k].a_rem                     = stage_q[k-1].a_rem;
        stage_d[k].b_rem                     = stage_q[k-1].b_rem;
      end

      overflow_d = st_cout[STAGES-1] ^ st_cmsb[STAGES-1];
      zero_d     = (stage_d[STAGES-1].psum == '0);
    end

    // Flush wins over stall; data fields may keep stale contents.
    if (bus.flush) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_d[k].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q    <= '0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      stage_q    <= stage_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign bus.out_valid = stage_q[STAGES-1].valid;
  assign bus.sum       = stage_q[STAGES-1].psum;
  assign bus.c_out     = stage_q[STAGES-1].carry;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

  // Already-consumed operand chunks and the intermediate MSB-carry taps have no reader.
  logic unused_bits;
  assign unused_bits = ^{stage_q, st_cmsb};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder at WIDTH=8, STAGES=2.
// Expected results come from a reference model when a bundle is accepted and are popped on each output handshake.

module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  localparam int W = 8;
  localparam int S = 2;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n;
  int     total = 0;
  int     bad   = 0;
  exp_t   sb[$];
  time    pop_times[$];
  exp_t   mon_exp;
  exp_t   mon_got;

  pipelined_adder_if #(.WIDTH(W)) bus();

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0]   full;
    logic [W-1:0] r;
    exp_t         e;
    if (!s) full = {1'b0, a} + {1'b0, b};
    else    full = {1'b0, a} + {1'b0, ~b} + 9'd1;
    r       = full[W-1:0];
    e.sum   = r;
    e.c_out = full[W];
    e.ovf   = s ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1]))
                : ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
    e.zero  = (r == '0);
    return e;
  endfunction

  // Output monitor: samples two time units after the falling edge, when out_ready is settled.
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      pop_times.push_back($time);
      mon_got = '{bus.sum, bus.c_out, bus.overflow, bus.zero};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result got sum=%h c=%b v=%b z=%b want no output",
                 mon_got.sum, mon_got.c_out, mon_got.ovf, mon_got.zero);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL result got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                   mon_got.sum, mon_got.c_out, mon_got.ovf, mon_got.zero,
                   mon_exp.sum, mon_exp.c_out, mon_exp.ovf, mon_exp.zero);
        end
      end
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bit done = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (bus.in_ready) begin
        sb.push_back(model(a, b, s));
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout got in_ready=0 want 1");
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got pending=%0d want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got %b want 0", bus.out_valid);
    end
    total++;
    if ({bus.sum, bus.c_out, bus.overflow, bus.zero} !== 11'h0) begin
      bad++; $display("FAIL reset_outputs got sum=%h c=%b v=%b z=%b want all 0",
                      bus.sum, bus.c_out, bus.overflow, bus.zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_add_overflow();
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(8'h7F, 8'h01, 1'b0);
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL latency_early got out_valid=%b want 0", bus.out_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL latency got out_valid=%b want 1", bus.out_valid);
    end
    total++;
    if ({bus.sum, bus.c_out, bus.overflow, bus.zero} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL add_ovf got sum=%h c=%b v=%b z=%b want sum=80 c=0 v=1 z=0",
                      bus.sum, bus.c_out, bus.overflow, bus.zero);
    end
    drain("add_ovf");
  endtask

  task automatic test_sub();
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(8'h05, 8'h05, 1'b1);
    drive(8'h00, 8'h01, 1'b1);
    bus.in_valid = 1'b0;
    #1;
    total++;
    if ({bus.sum, bus.c_out, bus.overflow, bus.zero} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL sub_zero got sum=%h c=%b v=%b z=%b want sum=00 c=1 v=0 z=1",
                      bus.sum, bus.c_out, bus.overflow, bus.zero);
    end
    @(negedge clk);
    #1;
    total++;
    if ({bus.sum, bus.c_out} !== {8'hFF, 1'b0}) begin
      bad++; $display("FAIL sub_borrow got sum=%h c=%b want sum=ff c=0", bus.sum, bus.c_out);
    end
    drain("sub");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.out_ready = 1'b1;
    pop_times.delete();
    drive(8'h10, 8'h01, 1'b0);
    drive(8'h20, 8'h02, 1'b0);
    drive(8'h30, 8'h03, 1'b0);
    drive(8'h40, 8'h04, 1'b0);
    drain("b2b");
    total++;
    if (pop_times.size() != 4) begin
      bad++; $display("FAIL b2b_count got %0d want 4", pop_times.size());
    end
    for (int i = 1; i < pop_times.size(); i++) begin
      total++;
      if (pop_times[i] - pop_times[i-1] != 10) begin
        bad++; $display("FAIL b2b_gap got %0t want 10 at result %0d", pop_times[i] - pop_times[i-1], i);
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    bus.out_ready = 1'b1;
    pop_times.delete();
    fork
      begin
        drive(8'h10, 8'h01, 1'b0);
        drive(8'h20, 8'h02, 1'b0);
        drive(8'h30, 8'h03, 1'b0);
        drive(8'h40, 8'h04, 1'b0);
        bus.in_valid = 1'b0;
      end
      begin
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          if (bus.out_valid) seen = 1'b1;
        end
        if (!seen) begin
          total++; bad++;
          $display("FAIL stall_first got out_valid=0 want 1 within 20 cycles");
        end else begin
          bus.out_ready = 1'b0;
          for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.in_ready !== 1'b0) begin
              bad++; $display("FAIL stall_in_ready got %b want 0 cycle %0d", bus.in_ready, i);
            end
            total++;
            if (bus.out_valid !== 1'b1 || bus.sum !== 8'h11) begin
              bad++; $display("FAIL stall_hold got valid=%b sum=%h want valid=1 sum=11 cycle %0d",
                              bus.out_valid, bus.sum, i);
            end
            @(negedge clk);
          end
          bus.out_ready = 1'b1;
        end
      end
    join
    drain("stall");
    total++;
    if (pop_times.size() != 4) begin
      bad++; $display("FAIL stall_count got %0d want 4", pop_times.size());
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(8'h21, 8'h11, 1'b0);
    drive(8'h42, 8'h22, 1'b0);
    bus.flush    = 1'b1;
    bus.a        = 8'h63;
    bus.b        = 8'h33;
    bus.sub      = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready);
    end
    sb.delete();
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_valid got %b want 0", bus.out_valid);
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL flush_quiet got out_valid=%b want 0", bus.out_valid);
      end
    end
    @(negedge clk);
    drive(8'h12, 8'h34, 1'b0);
    drain("flush");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(8'h55, 8'h22, 1'b0);
    drive(8'h66, 8'h11, 1'b0);
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL rst_full got out_valid=%b want 1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_async_valid got %b want 0", bus.out_valid);
    end
    total++;
    if ({bus.sum, bus.c_out, bus.overflow, bus.zero} !== 11'h0) begin
      bad++; $display("FAIL rst_async_out got sum=%h c=%b v=%b z=%b want all 0",
                      bus.sum, bus.c_out, bus.overflow, bus.zero);
    end
    sb.delete();
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++; $display("FAIL rst_quiet got out_valid=%b want 0", bus.out_valid);
      end
    end
    @(negedge clk);
    drive(8'h01, 8'h02, 1'b0);
    bus.in_valid = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_relatency_early got %b want 0", bus.out_valid);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 8'h03) begin
      bad++; $display("FAIL rst_relatency got valid=%b sum=%h want valid=1 sum=03", bus.out_valid, bus.sum);
    end
    drain("rst_mid");
  endtask

  task automatic test_random();
    @(negedge clk);
    pop_times.delete();
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          if ($urandom_range(0, 2) == 0) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
          end
          drive(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        bus.in_valid = 1'b0;
      end
      begin
        repeat (60) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain("random");
    total++;
    if (pop_times.size() != 24) begin
      bad++; $display("FAIL random_count got %0d want 24", pop_times.size());
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_add_overflow();
    test_sub();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
